dmem_loader: RTL and testbench
==============================

Name: dmem_loader

Overview:
- Upstream stage of the data memory. Takes a byte stream from the UART receiver and packs each pair of bytes into one 12-bit word.
- Writes the words sequentially into data memory over its write port (write_en / addr / datain), starting at a programmable base address.
- Used to preload matrix operands before the processor runs. Drives the memory port only while busy; the top level muxes it with the core.

Parameters:
- N, 17, bus/datain width of the data memory; words are zero-extended from 12 to N bits.
- MAX_WORDS, 4096, upper bound on word_count; larger requests are clamped to MAX_WORDS.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse; begins a load when idle.
- base_addr  input  12  first memory address written.
- word_count  input  13  number of 12-bit words to load (0..4096).
- rx_data  input  8  received byte.
- rx_valid  input  1  one-cycle strobe, rx_data valid.
- rx_ready  output  1  high when a byte can be accepted.
- write_en  output  1  data memory write strobe.
- addr  output  12  data memory address.
- datain  output  N  data memory write data.
- busy  output  1  load in progress.
- done  output  1  level; load completed, held until next accepted start.
- err  output  1  level; protocol error, held until next accepted start.

Behaviour:
- Reset (async, any state): state=IDLE; write_en=0, addr=0, datain=0, busy=0, done=0, err=0, rx_ready=0; internal count=0, byte latch=0. A load in progress is abandoned and no write is issued after reset asserts.
- FSM states: IDLE, LO, HI, WR, FIN.
- IDLE:
  - start=1 latches base_addr into addr and min(word_count, MAX_WORDS) into count, clears done/err, sets busy.
  - Next state is LO, or FIN if count==0.
- LO: rx_ready=1. On rx_valid, latch rx_data as bits [7:0]; go to HI.
- HI: rx_ready=1. On rx_valid:
  - rx_data[3:0] becomes bits [11:8].
  - rx_data[7:4] must be 0; a nonzero nibble sets err (the word is still written).
  - Go to WR.
- WR: rx_ready=0; write_en=1 for exactly this cycle.
  - datain = {(N-12) zeros, word}; addr = current address.
  - On exit: addr increments modulo 4096 (4095 wraps to 0) and count decrements.
  - Next state is LO, or FIN if count reaches 0.
- FIN: busy=0, done=1; return to IDLE the same cycle. done and err hold until the next accepted start.
- Latency: write_en asserts the cycle after the second byte's rx_valid. Minimum 3 cycles per word.
- rx_valid arriving when rx_ready=0 (IDLE, WR, FIN) is dropped. In WR or FIN it sets err (overrun); in IDLE it is ignored.
- start while busy is ignored.
- Outputs are registered. write_en is 0 in every state except WR. addr and datain hold their last values outside WR.

Optional Feature:
- Macro: DMEM_LOADER_CHECKSUM_EN.
- When defined:
  - After the last word, the FSM enters an extra state CK (rx_ready=1) and waits for one checksum byte.
  - The checksum must equal the XOR of all data bytes received in this load.
  - A mismatch sets err. In both cases the FSM then goes to FIN.
  - For word_count=0 a checksum of 0x00 is expected.
- When undefined: state CK and the XOR register are absent; FIN follows the last WR directly.

Test Plan:
- Basic load: start with base_addr=4, word_count=2, bytes 0x15,0x00,0x16,0x00 → writes 21 to addr 4, then 22 to addr 5; write_en pulses exactly twice; done=1, err=0, busy=0 afterwards.
- Wrap-around: base_addr=4095, word_count=2, bytes 0xFF,0x0F,0x01,0x00 → 0xFFF written to 4095, then 0x001 written to 0; done=1.
- Bad high nibble: word_count=1, bytes 0x05,0x31 → writes 0x105 to base_addr, err=1, done=1.
- Zero count and ignored start: word_count=0 → done=1 within 2 cycles, no write_en. A second start pulse while busy during a 3-word load → addresses unaffected, exactly 3 writes.
- Reset mid-load: assert rst after the first byte of word 2 → all outputs 0 immediately; a later rx_valid produces no write; a fresh start loads normally.
- Checksum (DMEM_LOADER_CHECKSUM_EN): bytes 0x15,0x00,0x16,0x00 then checksum 0x03 → err=0. Repeat with checksum 0x04 → err=1. Both end with done=1.

Source files
------------

// File: rtl/dmem_loader.sv
// dmem_loader: packs pairs of UART bytes into 12-bit words and writes them
// sequentially into data memory starting at a programmable base address.
// Optional feature macro: DMEM_LOADER_CHECKSUM_EN (trailing XOR checksum byte).
module dmem_loader #(
  parameter int unsigned N         = 17,
  parameter int unsigned MAX_WORDS = 4096
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [11:0]  base_addr,
  input  logic [12:0]  word_count,
  input  logic [7:0]   rx_data,
  input  logic         rx_valid,
  output logic         rx_ready,
  output logic         write_en,
  output logic [11:0]  addr,
  output logic [N-1:0] datain,
  output logic         busy,
  output logic         done,
  output logic         err
);

  localparam int unsigned AW = 12;
  localparam int unsigned CW = 13;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LO   = 3'd1,
    HI   = 3'd2,
    WR   = 3'd3,
    FIN  = 3'd4,
    CK   = 3'd5
  } state_t;

  state_t        state;
  logic [CW-1:0] count;
  logic [7:0]    lo_byte;
  logic [CW-1:0] req_count_c;

`ifdef DMEM_LOADER_CHECKSUM_EN
  logic [7:0]    xor_acc;
`endif

  // Requested word count clamped to the memory capacity
  assign req_count_c = (word_count > CW'(MAX_WORDS)) ? CW'(MAX_WORDS) : word_count;

  // Load sequencer with registered memory-port and handshake outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      count    <= '0;
      lo_byte  <= '0;
      rx_ready <= 1'b0;
      write_en <= 1'b0;
      addr     <= '0;
      datain   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
`ifdef DMEM_LOADER_CHECKSUM_EN
      xor_acc  <= '0;
`endif
    end else begin
      write_en <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            addr  <= base_addr;
            count <= req_count_c;
            done  <= 1'b0;
            err   <= 1'b0;
            busy  <= 1'b1;
`ifdef DMEM_LOADER_CHECKSUM_EN
            xor_acc <= '0;
`endif
            if (req_count_c == '0) begin
`ifdef DMEM_LOADER_CHECKSUM_EN
              state    <= CK;
              rx_ready <= 1'b1;
`else
              state    <= FIN;
              rx_ready <= 1'b0;
`endif
            end else begin
              state    <= LO;
              rx_ready <= 1'b1;
            end
          end
        end

        LO: begin
          if (rx_valid) begin
            lo_byte <= rx_data;
`ifdef DMEM_LOADER_CHECKSUM_EN
            xor_acc <= xor_acc ^ rx_data;
`endif
            state   <= HI;
          end
        end

        HI: begin
          if (rx_valid) begin
            datain   <= N'({rx_data[3:0], lo_byte});
            // Upper nibble must be zero; the word is written regardless
            if (rx_data[7:4] != 4'h0) begin
              err <= 1'b1;
            end
`ifdef DMEM_LOADER_CHECKSUM_EN
            xor_acc  <= xor_acc ^ rx_data;
`endif
            write_en <= 1'b1;
            rx_ready <= 1'b0;
            state    <= WR;
          end
        end

        WR: begin
          addr  <= addr + AW'(1);
          count <= count - CW'(1);
          // A byte offered while not ready is lost: overrun
          if (rx_valid) begin
            err <= 1'b1;
          end
          if (count == CW'(1)) begin
`ifdef DMEM_LOADER_CHECKSUM_EN
            state    <= CK;
            rx_ready <= 1'b1;
`else
            state    <= FIN;
            rx_ready <= 1'b0;
`endif
          end else begin
            state    <= LO;
            rx_ready <= 1'b1;
          end
        end

`ifdef DMEM_LOADER_CHECKSUM_EN
        CK: begin
          if (rx_valid) begin
            if (rx_data != xor_acc) begin
              err <= 1'b1;
            end
            rx_ready <= 1'b0;
            state    <= FIN;
          end
        end
`endif

        FIN: begin
          busy  <= 1'b0;
          done  <= 1'b1;
          if (rx_valid) begin
            err <= 1'b1;
          end
          state <= IDLE;
        end

        default: begin
          state    <= IDLE;
          rx_ready <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_loader.sv
// Directed self-checking bench for dmem_loader: a cycle table for the basic
// load plus hand-written sequences for wrap, error, zero-count, reset cases.
module tb_dmem_loader;

  localparam int unsigned N = 17;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [11:0]  base_addr;
  logic [12:0]  word_count;
  logic [7:0]   rx_data;
  logic         rx_valid;
  logic         rx_ready;
  logic         write_en;
  logic [11:0]  addr;
  logic [N-1:0] datain;
  logic         busy;
  logic         done;
  logic         err;

  int checks   = 0;
  int failures = 0;

  logic [11:0]  wa_q[$];
  logic [N-1:0] wd_q[$];

  dmem_loader #(.N(N), .MAX_WORDS(4096)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .base_addr  (base_addr),
    .word_count (word_count),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .write_en   (write_en),
    .addr       (addr),
    .datain     (datain),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  // Record every memory write, sampled mid-cycle
  always @(negedge clk) begin
    if (write_en === 1'b1) begin
      wa_q.push_back(addr);
      wd_q.push_back(datain);
    end
  end

  typedef struct {
    logic         start;
    logic [11:0]  base;
    logic [12:0]  wc;
    logic         rv;
    logic [7:0]   rd;
    logic         we;
    logic [11:0]  addr;
    logic [N-1:0] din;
    logic         rdy;
    logic         busy;
    logic         done;
    logic         err;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_writes();
    wa_q.delete();
    wd_q.delete();
  endtask

  task automatic do_start(input logic [11:0] b, input logic [12:0] wc);
    base_addr  = b;
    word_count = wc;
    start      = 1'b1;
    cyc();
    start      = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    while (rx_ready !== 1'b1 && n < 50) begin
      cyc();
      n++;
    end
    if (n >= 50) check("rx_ready_timeout", 32'(rx_ready), 32'd1);
    rx_data  = b;
    rx_valid = 1'b1;
    cyc();
    rx_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 100) begin
      cyc();
      n++;
    end
    check(name, 32'(done), 32'd1);
  endtask

  task automatic check_wr(input string name, input int idx, input logic [11:0] a, input logic [N-1:0] d);
    if (idx < wa_q.size()) begin
      check({name, "_addr"}, 32'(wa_q[idx]), 32'(a));
      check({name, "_data"}, 32'(wd_q[idx]), 32'(d));
    end else begin
      check({name, "_missing"}, 32'(wa_q.size()), 32'(idx + 1));
    end
  endtask

  initial begin
    vec_t tbl[9];

    rst        = 1'b1;
    start      = 1'b0;
    base_addr  = '0;
    word_count = '0;
    rx_data    = '0;
    rx_valid   = 1'b0;
    cyc();
    cyc();
    check("reset_write_en", 32'(write_en), 32'd0);
    check("reset_addr",     32'(addr),     32'd0);
    check("reset_datain",   32'(datain),   32'd0);
    check("reset_busy",     32'(busy),     32'd0);
    check("reset_done",     32'(done),     32'd0);
    check("reset_err",      32'(err),      32'd0);
    check("reset_rx_ready", 32'(rx_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    cyc();

`ifndef DMEM_LOADER_CHECKSUM_EN
    // Basic load: base 4, two words 21 and 22, checked cycle by cycle
    //          start  base   wc     rv    rd      we    addr    din     rdy   busy  done  err
    tbl[0] = '{1'b1, 12'd4, 13'd2, 1'b0, 8'h00, 1'b0, 12'd4, 17'd0,  1'b1, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 12'd4, 13'd2, 1'b1, 8'h15, 1'b0, 12'd4, 17'd0,  1'b1, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 12'd4, 13'd2, 1'b1, 8'h00, 1'b1, 12'd4, 17'd21, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 12'd4, 13'd2, 1'b0, 8'h00, 1'b0, 12'd5, 17'd21, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 12'd4, 13'd2, 1'b1, 8'h16, 1'b0, 12'd5, 17'd21, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[5] = '{1'b0, 12'd4, 13'd2, 1'b1, 8'h00, 1'b1, 12'd5, 17'd22, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[6] = '{1'b0, 12'd4, 13'd2, 1'b0, 8'h00, 1'b0, 12'd6, 17'd22, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[7] = '{1'b0, 12'd4, 13'd2, 1'b0, 8'h00, 1'b0, 12'd6, 17'd22, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[8] = '{1'b0, 12'd4, 13'd2, 1'b1, 8'h77, 1'b0, 12'd6, 17'd22, 1'b0, 1'b0, 1'b1, 1'b0};
    clear_writes();
    for (int i = 0; i < 9; i++) begin
      start      = tbl[i].start;
      base_addr  = tbl[i].base;
      word_count = tbl[i].wc;
      rx_valid   = tbl[i].rv;
      rx_data    = tbl[i].rd;
      cyc();
      check($sformatf("tbl%0d_write_en", i), 32'(write_en), 32'(tbl[i].we));
      check($sformatf("tbl%0d_addr", i),     32'(addr),     32'(tbl[i].addr));
      check($sformatf("tbl%0d_datain", i),   32'(datain),   32'(tbl[i].din));
      check($sformatf("tbl%0d_rx_ready", i), 32'(rx_ready), 32'(tbl[i].rdy));
      check($sformatf("tbl%0d_busy", i),     32'(busy),     32'(tbl[i].busy));
      check($sformatf("tbl%0d_done", i),     32'(done),     32'(tbl[i].done));
      check($sformatf("tbl%0d_err", i),      32'(err),      32'(tbl[i].err));
    end
    start    = 1'b0;
    rx_valid = 1'b0;
    check("basic_nwrites", 32'(wa_q.size()), 32'd2);
`else
    // Basic load with matching checksum, then with a wrong one
    clear_writes();
    do_start(12'd4, 13'd2);
    send_byte(8'h15); send_byte(8'h00); send_byte(8'h16); send_byte(8'h00);
    send_byte(8'h03);
    wait_done("ck_good_done");
    check("ck_good_err", 32'(err), 32'd0);
    check("ck_good_nwrites", 32'(wa_q.size()), 32'd2);
    check_wr("ck_good_w0", 0, 12'd4, 17'd21);
    check_wr("ck_good_w1", 1, 12'd5, 17'd22);
    cyc();
    clear_writes();
    do_start(12'd4, 13'd2);
    send_byte(8'h15); send_byte(8'h00); send_byte(8'h16); send_byte(8'h00);
    send_byte(8'h04);
    wait_done("ck_bad_done");
    check("ck_bad_err", 32'(err), 32'd1);
`endif
    cyc();

    // Address wrap from 4095 to 0
    clear_writes();
    do_start(12'd4095, 13'd2);
    send_byte(8'hFF); send_byte(8'h0F); send_byte(8'h01); send_byte(8'h00);
`ifdef DMEM_LOADER_CHECKSUM_EN
    send_byte(8'hF1);
`endif
    wait_done("wrap_done");
    check("wrap_err", 32'(err), 32'd0);
    check("wrap_nwrites", 32'(wa_q.size()), 32'd2);
    check_wr("wrap_w0", 0, 12'd4095, 17'h00FFF);
    check_wr("wrap_w1", 1, 12'd0,    17'h00001);
    cyc();

    // Nonzero high nibble flags err but the word is still written
    clear_writes();
    do_start(12'd100, 13'd1);
    send_byte(8'h05); send_byte(8'h31);
`ifdef DMEM_LOADER_CHECKSUM_EN
    send_byte(8'h34);
`endif
    wait_done("nibble_done");
    check("nibble_err", 32'(err), 32'd1);
    check("nibble_nwrites", 32'(wa_q.size()), 32'd1);
    check_wr("nibble_w0", 0, 12'd100, 17'h00105);
    cyc();

    // Zero word count: no writes, done promptly, err cleared by the start
    clear_writes();
    do_start(12'd200, 13'd0);
    check("zero_busy", 32'(busy), 32'd1);
    check("zero_err_cleared", 32'(err), 32'd0);
`ifdef DMEM_LOADER_CHECKSUM_EN
    send_byte(8'h00);
    wait_done("zero_done");
`else
    cyc();
    check("zero_done", 32'(done), 32'd1);
`endif
    check("zero_busy_after", 32'(busy), 32'd0);
    check("zero_err", 32'(err), 32'd0);
    check("zero_nwrites", 32'(wa_q.size()), 32'd0);
    cyc();

    // Start pulse during a load is ignored
    clear_writes();
    do_start(12'd10, 13'd3);
    do_start(12'd50, 13'd1);
    send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h02); send_byte(8'h00);
    send_byte(8'h03); send_byte(8'h00);
`ifdef DMEM_LOADER_CHECKSUM_EN
    send_byte(8'h00);
`endif
    wait_done("ign_done");
    check("ign_err", 32'(err), 32'd0);
    check("ign_nwrites", 32'(wa_q.size()), 32'd3);
    check_wr("ign_w0", 0, 12'd10, 17'd1);
    check_wr("ign_w1", 1, 12'd11, 17'd2);
    check_wr("ign_w2", 2, 12'd12, 17'd3);
    cyc();

    // Asynchronous reset after the first byte of word 2
    clear_writes();
    do_start(12'd20, 13'd3);
    send_byte(8'h11); send_byte(8'h00);
    send_byte(8'h22);
    #2;
    rst = 1'b1;
    #1;
    check("rst_write_en", 32'(write_en), 32'd0);
    check("rst_addr",     32'(addr),     32'd0);
    check("rst_datain",   32'(datain),   32'd0);
    check("rst_busy",     32'(busy),     32'd0);
    check("rst_rx_ready", 32'(rx_ready), 32'd0);
    check("rst_done",     32'(done),     32'd0);
    check("rst_err",      32'(err),      32'd0);
    cyc();
    @(negedge clk);
    rst = 1'b0;
    cyc();
    rx_data  = 8'h33;
    rx_valid = 1'b1;
    cyc(); cyc(); cyc();
    rx_valid = 1'b0;
    cyc();
    check("rst_idle_busy", 32'(busy), 32'd0);
    check("rst_idle_err",  32'(err),  32'd0);
    check("rst_nwrites", 32'(wa_q.size()), 32'd1);
    check_wr("rst_w0", 0, 12'd20, 17'h00011);
    do_start(12'd30, 13'd1);
    send_byte(8'h07); send_byte(8'h00);
`ifdef DMEM_LOADER_CHECKSUM_EN
    send_byte(8'h07);
`endif
    wait_done("rst_reload_done");
    check("rst_reload_err", 32'(err), 32'd0);
    check("rst_reload_nwrites", 32'(wa_q.size()), 32'd2);
    check_wr("rst_reload_w", 1, 12'd30, 17'd7);
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
